// File: rtl/intersection_scheduler.sv
// Phase sequencer for a two-approach intersection (main road A, side road B,
// pedestrian crossing). Main road rests in green until a side-road or
// pedestrian request is pending; en_i low forces flashing yellow.
// All durations are in ticks of an internal prescaler (TICK_DIV clk cycles).
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous reset, active-high
//   en_i        1 = normal sequencing, 0 = flashing yellow
//   side_req_i  side-road vehicle sensor (level)
//   ped_req_i   pedestrian button (pulse or level)
//   color_a_o   main-road lamps {R,Y,G}
//   color_b_o   side-road lamps {R,Y,G}
//   walk_o      pedestrian walk lamp
//   ped_ack_o   one-cycle pulse on the first cycle of a walk phase
//   phase_o     current state encoding
module intersection_scheduler #(
   parameter int unsigned TICK_DIV  = 1000,
   parameter int unsigned GREEN_A   = 40,
   parameter int unsigned GREEN_B   = 20,
   parameter int unsigned YELLOW_ON = 5,
   parameter int unsigned ALL_RED   = 2,
   parameter int unsigned WALK_ON   = 10,
   parameter int unsigned BLINKING  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en_i,
   input  logic       side_req_i,
   input  logic       ped_req_i,
   output logic [2:0] color_a_o,
   output logic [2:0] color_b_o,
   output logic       walk_o,
   output logic       ped_ack_o,
   output logic [2:0] phase_o
);

   typedef enum logic [2:0] {
      RED_AB   = 3'd0,
      A_GREEN  = 3'd1,
      A_YELLOW = 3'd2,
      B_GREEN  = 3'd3,
      B_YELLOW = 3'd4,
      RED_BA   = 3'd5,
      WALK     = 3'd6,
      FLASH    = 3'd7
   } state_t;

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   localparam int unsigned MAX_1 = (GREEN_A > GREEN_B) ? GREEN_A : GREEN_B;
   localparam int unsigned MAX_2 = (MAX_1 > YELLOW_ON) ? MAX_1 : YELLOW_ON;
   localparam int unsigned MAX_3 = (MAX_2 > ALL_RED) ? MAX_2 : ALL_RED;
   localparam int unsigned MAX_4 = (MAX_3 > WALK_ON) ? MAX_3 : WALK_ON;
   localparam int unsigned MAX_DUR = (MAX_4 > BLINKING) ? MAX_4 : BLINKING;
   localparam int unsigned TW = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;

   localparam logic [2:0] LAMP_R   = 3'b100;
   localparam logic [2:0] LAMP_Y   = 3'b010;
   localparam logic [2:0] LAMP_G   = 3'b001;
   localparam logic [2:0] LAMP_OFF = 3'b000;

   state_t          state, state_next;
   logic [PW-1:0]   presc, presc_next;
   logic [TW-1:0]   timer, timer_next;
   logic            blink, blink_next;
   logic            side_pend, side_next;
   logic            ped_pend, ped_next;
   logic            ack_next;
   logic [2:0]      color_a_next, color_b_next;
   logic            walk_next;
   logic            tick_c;
   logic            expiry_c;

   // Timer reload value (duration minus one) for the state being entered.
   function automatic logic [TW-1:0] load_val(input state_t s);
      logic [TW-1:0] v;
      v = TW'(ALL_RED - 1);
      case (s)
         A_GREEN:            v = TW'(GREEN_A - 1);
         A_YELLOW, B_YELLOW: v = TW'(YELLOW_ON - 1);
         B_GREEN:            v = TW'(GREEN_B - 1);
         WALK:               v = TW'(WALK_ON - 1);
         FLASH:              v = TW'(BLINKING - 1);
         default:            v = TW'(ALL_RED - 1);
      endcase
      return v;
   endfunction

   assign tick_c   = (presc == PW'(TICK_DIV - 1));
   assign expiry_c = tick_c && (timer == '0);
   assign phase_o  = 3'(state);

   // Next-state, timers, request latches and lamp decode.
   always_comb begin
      state_next   = state;
      presc_next   = tick_c ? '0 : presc + PW'(1);
      timer_next   = (tick_c && (timer != '0)) ? timer - TW'(1) : timer;
      blink_next   = blink;
      side_next    = side_pend | side_req_i;
      ped_next     = ped_pend | ped_req_i;
      ack_next     = 1'b0;
      color_a_next = LAMP_R;
      color_b_next = LAMP_R;
      walk_next    = 1'b0;

      if (!en_i) begin
         state_next = FLASH;
         if ((state == FLASH) && expiry_c) begin
            blink_next = ~blink;
            timer_next = load_val(FLASH);
         end
      end else begin
         case (state)
            RED_AB:
               if (expiry_c) begin
                  if (side_pend)     state_next = B_GREEN;
                  else if (ped_pend) state_next = WALK;
                  else               state_next = A_GREEN;
               end
            // Rests here with timer at zero until a request is pending.
            A_GREEN:  if (expiry_c && (side_pend || ped_pend)) state_next = A_YELLOW;
            A_YELLOW: if (expiry_c) state_next = RED_AB;
            B_GREEN:  if (expiry_c) state_next = B_YELLOW;
            B_YELLOW: if (expiry_c) state_next = RED_BA;
            RED_BA:   if (expiry_c) state_next = ped_pend ? WALK : A_GREEN;
            WALK:     if (expiry_c) state_next = A_GREEN;
            FLASH:    state_next = RED_AB;
            default:  state_next = RED_AB;
         endcase
      end

      // State entry: restart timing; a request clear beats a same-cycle set.
      if (state_next != state) begin
         presc_next = '0;
         timer_next = load_val(state_next);
         if (state_next == FLASH)   blink_next = 1'b1;
         if (state_next == B_GREEN) side_next  = 1'b0;
         if (state_next == WALK) begin
            ped_next = 1'b0;
            ack_next = 1'b1;
         end
      end

      case (state_next)
         A_GREEN:  color_a_next = LAMP_G;
         A_YELLOW: color_a_next = LAMP_Y;
         B_GREEN:  color_b_next = LAMP_G;
         B_YELLOW: color_b_next = LAMP_Y;
         WALK:     walk_next    = 1'b1;
         FLASH: begin
            color_a_next = blink_next ? LAMP_Y : LAMP_OFF;
            color_b_next = blink_next ? LAMP_Y : LAMP_OFF;
         end
         default: begin
            color_a_next = LAMP_R;
            color_b_next = LAMP_R;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= RED_AB;
         presc     <= '0;
         timer     <= TW'(ALL_RED - 1);
         blink     <= 1'b0;
         side_pend <= 1'b0;
         ped_pend  <= 1'b0;
         ped_ack_o <= 1'b0;
         color_a_o <= LAMP_R;
         color_b_o <= LAMP_R;
         walk_o    <= 1'b0;
      end else begin
         state     <= state_next;
         presc     <= presc_next;
         timer     <= timer_next;
         blink     <= blink_next;
         side_pend <= side_next;
         ped_pend  <= ped_next;
         ped_ack_o <= ack_next;
         color_a_o <= color_a_next;
         color_b_o <= color_b_next;
         walk_o    <= walk_next;
      end
   end

endmodule
